// File: rtl/srt4_seq_ctrl.sv
// Sequencer for the 8-bit radix-4 SRT divider: load, normalise, four digit iterations,
// correction, quotient formation, denormalisation and read-out.
module srt4_seq_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned ITER  = W / 2,
  parameter int unsigned NCTRL = 17
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             beginSignal,
  input  logic             b7,
  input  logic [2:0]       msbp,
  output logic [NCTRL-1:0] control_signals,
  output logic             endSignal,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned NW = $clog2(W);
  localparam int unsigned IW = $clog2(ITER);
  localparam logic [NW-1:0] NormMax = NW'(W - 1);
  localparam logic [IW-1:0] IterMax = IW'(ITER - 1);

  localparam int unsigned CClr   = 0;
  localparam int unsigned CLdA   = 1;
  localparam int unsigned CLdP   = 2;
  localparam int unsigned CLdB   = 3;
  localparam int unsigned CNorm  = 4;
  localparam int unsigned CShl2  = 5;
  localparam int unsigned CAddB  = 6;
  localparam int unsigned CSubB  = 7;
  localparam int unsigned CAdd2B = 8;
  localparam int unsigned CSub2B = 9;
  localparam int unsigned CQ0    = 10;
  localparam int unsigned CQ1    = 11;
  localparam int unsigned CCorr  = 12;
  localparam int unsigned CQuot  = 13;
  localparam int unsigned CShr   = 14;
  localparam int unsigned COutA  = 15;
  localparam int unsigned COutP  = 16;

  typedef enum logic [3:0] {
    StIdle, StInit, StLdp, StLda, StLdb, StNorm, StShift,
    StOp, StCorr, StQuot, StDenorm, StOutq, StOutr, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [NW-1:0]    norm_q, norm_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [NCTRL-1:0] ctrl;
  logic             end_c, dz_c;

  always_comb begin
    state_d = state_q;
    norm_d  = norm_q;
    iter_d  = iter_q;
    ctrl    = '0;
    end_c   = 1'b0;
    dz_c    = 1'b0;
    unique case (state_q)
      StIdle: if (beginSignal) state_d = StInit;
      StInit: begin
        ctrl[CClr] = 1'b1;
        norm_d     = '0;
        iter_d     = '0;
        state_d    = StLdp;
      end
      StLdp: begin ctrl[CLdP] = 1'b1; state_d = StLda; end
      StLda: begin ctrl[CLdA] = 1'b1; state_d = StLdb; end
      StLdb: begin ctrl[CLdB] = 1'b1; state_d = StNorm; end
      StNorm: begin
        if (b7) begin
          state_d = StShift;
        end else if (norm_q != NormMax) begin
          ctrl[CNorm] = 1'b1;
          norm_d      = norm_q + 1'b1;
        end else begin
          // Zero divisor: this cycle is the done cycle, so the pulse lands without a DONE visit.
          end_c   = 1'b1;
          dz_c    = 1'b1;
          state_d = StIdle;
        end
      end
      StShift: begin ctrl[CShl2] = 1'b1; state_d = StOp; end
      StOp: begin
        // Negative digits set A' bits; SHIFT routed digit writes to A'.
        case (msbp)
          3'b001:         begin ctrl[CSubB]  = 1'b1; ctrl[CQ0] = 1'b1; end
          3'b010, 3'b011: begin ctrl[CSub2B] = 1'b1; ctrl[CQ1] = 1'b1; end
          3'b110:         begin ctrl[CAddB]  = 1'b1; ctrl[CQ0] = 1'b1; end
          3'b100, 3'b101: begin ctrl[CAdd2B] = 1'b1; ctrl[CQ1] = 1'b1; end
          default:        ;
        endcase
        if (iter_q == IterMax) begin
          iter_d  = '0;
          state_d = StCorr;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = StShift;
        end
      end
      StCorr: begin
        if (msbp[2]) ctrl[CCorr] = 1'b1;
        state_d = StQuot;
      end
      StQuot: begin ctrl[CQuot] = 1'b1; state_d = StDenorm; end
      StDenorm: begin
        if (norm_q != '0) begin
          ctrl[CShr] = 1'b1;
          norm_d     = norm_q - 1'b1;
        end else begin
          state_d = StOutq;
        end
      end
      StOutq: begin ctrl[COutA] = 1'b1; state_d = StOutr; end
      StOutr: begin ctrl[COutP] = 1'b1; state_d = StDone; end
      StDone: begin end_c = 1'b1; state_d = StIdle; end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is asserted so an abort never leaks a control pulse.
  assign control_signals = rst_b ? '0 : ctrl;
  assign endSignal       = end_c & ~rst_b;
  assign div_by_zero     = dz_c & ~rst_b;
  assign busy            = (state_q != StIdle) & ~rst_b;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= StIdle;
      norm_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      norm_q  <= norm_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_srt4_seq_ctrl.sv
// Bench for srt4_seq_ctrl: per-cycle schedule of expected controls built from the
// sequencing rules, with randomised digits, normalisation depths and don't-care inputs.
module tb_srt4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        beginSignal;
  logic        b7;
  logic [2:0]  msbp;
  logic [16:0] control_signals;
  logic        endSignal;
  logic        div_by_zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  srt4_seq_ctrl dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .beginSignal     (beginSignal),
    .b7              (b7),
    .msbp            (msbp),
    .control_signals (control_signals),
    .endSignal       (endSignal),
    .div_by_zero     (div_by_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] cb(input int k);
    logic [16:0] w;
    w    = '0;
    w[k] = 1'b1;
    return w;
  endfunction

  function automatic logic [16:0] digit(input logic [2:0] m);
    case (m)
      3'b001:         return cb(7) | cb(10);
      3'b010, 3'b011: return cb(9) | cb(11);
      3'b110:         return cb(6) | cb(10);
      3'b100, 3'b101: return cb(8) | cb(11);
      default:        return '0;
    endcase
  endfunction

  // Entry packing: {control_signals, endSignal, div_by_zero, busy}
  function automatic logic [19:0] ent(input logic [16:0] c, input logic e, input logic d);
    return {c, e, d, 1'b1};
  endfunction

  task automatic check_cycle(input string name, input int cyc, input logic [19:0] want);
    logic [19:0] obs;
    obs = {control_signals, endSignal, div_by_zero & endSignal, busy};
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got ctrl=%h end=%b dbz=%b busy=%b, want ctrl=%h end=%b dbz=%b busy=%b",
               name, cyc, obs[19:3], obs[2], obs[1], obs[0], want[19:3], want[2], want[1], want[0]);
    end
  endtask

  // One division: n normalisation shifts (n=7 with dz=1 means zero divisor), digit-select
  // values opm per OP step, corr for CORR. pulse_at gives a cycle to pulse beginSignal,
  // hold_end keeps beginSignal high through DONE, chained means INIT was already entered.
  task automatic run_div(input int n, input bit dz, input logic [11:0] opm, input logic [2:0] corr,
                         input int pulse_at, input bit hold_end, input bit chained,
                         input string name);
    logic [19:0] exp_q[$];
    int          len;
    exp_q = {};
    exp_q.push_back(ent(cb(0), 1'b0, 1'b0));
    exp_q.push_back(ent(cb(2), 1'b0, 1'b0));
    exp_q.push_back(ent(cb(1), 1'b0, 1'b0));
    exp_q.push_back(ent(cb(3), 1'b0, 1'b0));
    for (int i = 0; i < n; i++) exp_q.push_back(ent(cb(4), 1'b0, 1'b0));
    if (dz) begin
      exp_q.push_back(ent('0, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(ent('0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(ent(cb(5), 1'b0, 1'b0));
        exp_q.push_back(ent(digit(opm[3*i +: 3]), 1'b0, 1'b0));
      end
      exp_q.push_back(ent(corr[2] ? cb(12) : '0, 1'b0, 1'b0));
      exp_q.push_back(ent(cb(13), 1'b0, 1'b0));
      for (int i = 0; i < n; i++) exp_q.push_back(ent(cb(14), 1'b0, 1'b0));
      exp_q.push_back(ent('0, 1'b0, 1'b0));
      exp_q.push_back(ent(cb(15), 1'b0, 1'b0));
      exp_q.push_back(ent(cb(16), 1'b0, 1'b0));
      exp_q.push_back(ent('0, 1'b1, 1'b0));
    end
    len = exp_q.size();
    if (!chained) begin
      beginSignal = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < len; k++) begin
      beginSignal = (k + 1 == pulse_at) || (hold_end && k == len - 1);
      b7   = 1'($urandom);
      msbp = 3'($urandom);
      if (k >= 4 && k <= 4 + n) b7 = !dz && (k == 4 + n);
      for (int i = 0; i < 4; i++) if (!dz && k == 6 + n + 2 * i) msbp = opm[3*i +: 3];
      if (!dz && k == 13 + n) msbp = corr;
      @(negedge clk);
      check_cycle(name, k + 1, exp_q[k]);
      @(posedge clk); #1;
    end
    beginSignal = hold_end;
    b7   = 1'($urandom);
    msbp = 3'($urandom);
    @(negedge clk);
    check_cycle({name, "_idle"}, len + 1, 20'h0);
    @(posedge clk); #1;
    beginSignal = 1'b0;
  endtask

  task automatic test_reset;
    rst_b = 1'b1;
    beginSignal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cycle("reset_hold", i, 20'h0);
      @(posedge clk); #1;
    end
    rst_b = 1'b0;
    beginSignal = 1'b0;
    @(negedge clk);
    check_cycle("reset_idle", 0, 20'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    beginSignal = 1'b1;
    @(posedge clk); #1;
    beginSignal = 1'b0;
    b7 = 1'b1;
    repeat (7) begin
      msbp = 3'($urandom);
      @(posedge clk); #1;
    end
    // Cycle 8 is the second SHIFT: only busy is known to be high here.
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_busy: got busy=%b, want 1", busy);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      msbp = 3'($urandom);
      @(negedge clk);
      check_cycle("reset_mid_hold", i, 20'h0);
      @(posedge clk); #1;
    end
    rst_b = 1'b0;
    for (int i = 0; i < 25; i++) begin
      b7   = 1'($urandom);
      msbp = 3'($urandom);
      @(negedge clk);
      check_cycle("reset_mid_after", i, 20'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_example;
    run_div(5, 1'b0, 12'($urandom), 3'($urandom), 0, 1'b0, 1'b0, "example_n5");
  endtask

  task automatic test_norm_immediate;
    run_div(0, 1'b0, 12'($urandom), 3'($urandom), 0, 1'b0, 1'b0, "norm_immediate");
  endtask

  task automatic test_div_zero;
    run_div(7, 1'b1, 12'($urandom), 3'($urandom), 0, 1'b0, 1'b0, "div_zero");
  endtask

  task automatic test_digits;
    run_div(2, 1'b0, {3'b100, 3'b110, 3'b011, 3'b001}, 3'b101, 0, 1'b0, 1'b0, "digits");
    run_div(1, 1'b0, {3'b111, 3'b000, 3'b101, 3'b010}, 3'b011, 0, 1'b0, 1'b0, "digits_b");
  endtask

  task automatic test_back_to_back;
    int n;
    n = $urandom_range(0, 7);
    run_div(n, 1'b0, 12'($urandom), 3'($urandom), 7 + n, 1'b1, 1'b0, "b2b_first");
    run_div(3, 1'b0, 12'($urandom), 3'($urandom), 0, 1'b0, 1'b1, "b2b_second");
  endtask

  task automatic test_random;
    int  n;
    bit  dz;
    for (int r = 0; r < 10; r++) begin
      dz = ($urandom_range(0, 3) == 0);
      n  = dz ? 7 : $urandom_range(0, 7);
      run_div(n, dz, 12'($urandom), 3'($urandom), 0, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    rst_b = 1'b1;
    beginSignal = 1'b0;
    b7 = 1'b0;
    msbp = 3'b000;
    test_reset;
    test_reset_mid;
    test_example;
    test_norm_immediate;
    test_div_zero;
    test_digits;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
